// File: rtl/int8_to_fp8_converter.sv
// Converts a signed 8-bit integer to the 8-bit {sign, exp[2:0], mant[3:0]} operand
// format by shifting right one bit per clock, then rounding once.
module int8_to_fp8_converter #(
   parameter bit ROUND_EN = 1'b1
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic [7:0] int_in,
   output logic       busy,
   output logic       done,
   output logic [7:0] fp_out
);

   typedef enum logic [1:0] {IDLE, NORM, ROUND} state_t;

   state_t     state;
   logic       sign;
   logic [8:0] mag;
   logic [2:0] exp_r;
   logic       guard;
   logic       sticky;

   logic [7:0] abs_in;
   logic       round_up;
   logic [4:0] mant_sum;
   logic       carry;

   // 0x80 negates to 0x80, which read as unsigned is the required 128
   assign abs_in   = int_in[7] ? (~int_in + 8'd1) : int_in;
   assign round_up = ROUND_EN && guard && (sticky || mag[0]);
   assign mant_sum = {1'b0, mag[3:0]} + {4'd0, round_up};
   assign carry    = mant_sum[4];

   always_ff @(posedge clk) begin
      if (clr) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         fp_out <= 8'h00;
         sign   <= 1'b0;
         mag    <= 9'd0;
         exp_r  <= 3'd0;
         guard  <= 1'b0;
         sticky <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sign   <= int_in[7];
                  mag    <= {1'b0, abs_in};
                  exp_r  <= 3'd0;
                  guard  <= 1'b0;
                  sticky <= 1'b0;
                  busy   <= 1'b1;
                  state  <= NORM;
               end
            end
            NORM: begin
               if (mag[8:4] != 5'd0) begin
                  sticky <= sticky | guard;
                  guard  <= mag[0];
                  mag    <= mag >> 1;
                  exp_r  <= exp_r + 3'd1;
               end else begin
                  state <= ROUND;
               end
            end
            ROUND: begin
               // mantissa overflow to 16 renormalizes to 8 with one more exponent
               fp_out <= {sign, carry ? (exp_r + 3'd1) : exp_r, carry ? 4'd8 : mant_sum[3:0]};
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_int8_to_fp8_converter.sv
// Scoreboard bench for int8_to_fp8_converter: a rounding instance and a truncating
// instance, expected results queued at issue and popped when done pulses.
module tb_int8_to_fp8_converter;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       start = 1'b0, start_t = 1'b0;
   logic [7:0] int_in = 8'h00, int_in_t = 8'h00;
   logic       busy, done, busy_t, done_t;
   logic [7:0] fp_out, fp_out_t;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] fp;
      int         lat;
   } exp_t;
   exp_t sb[$];

   int8_to_fp8_converter #(.ROUND_EN(1'b1)) dut (
      .clk(clk), .clr(clr), .start(start), .int_in(int_in),
      .busy(busy), .done(done), .fp_out(fp_out)
   );

   int8_to_fp8_converter #(.ROUND_EN(1'b0)) dut_t (
      .clk(clk), .clr(clr), .start(start_t), .int_in(int_in_t),
      .busy(busy_t), .done(done_t), .fp_out(fp_out_t)
   );

   always #5 clk = ~clk;

   // table: truncating instance?, input, expected fp_out, expected cycles to done
   localparam int NT = 14;
   bit         t_tr [NT] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
   logic [7:0] t_in [NT] = '{8'h00, 8'hFB, 8'h18, 8'h19, 8'h1B, 8'h64, 8'h1A,
                             8'h7F, 8'h80, 8'h7F, 8'h1B, 8'h01, 8'hF0, 8'h0F};
   logic [7:0] t_fp [NT] = '{8'h00, 8'h85, 8'h1C, 8'h1C, 8'h1E, 8'h3C, 8'h1D,
                             8'h48, 8'hC8, 8'h3F, 8'h1D, 8'h01, 8'h98, 8'h0F};
   int         t_lat[NT] = '{2, 2, 3, 3, 3, 5, 3, 5, 6, 5, 3, 2, 3, 2};

   // drive one start pulse at an IDLE cycle; returns 1 cycle after the accepting edge
   task automatic issue(input bit tr, input logic [7:0] v, input logic [7:0] efp, input int elat);
      if (tr) begin start_t = 1'b1; int_in_t = v; end
      else begin start = 1'b1; int_in = v; end
      sb.push_back('{efp, elat});
      @(posedge clk); #1;
      start = 1'b0; start_t = 1'b0;
      int_in = 8'hA5; int_in_t = 8'hA5;
   endtask

   // counts edges until done; n = -1 if done never came within the budget
   task automatic wait_done(input bit tr, output int n, output logic [7:0] fp);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!(tr ? done_t : done) && n < 12);
      if (!(tr ? done_t : done)) n = -1;
      fp = tr ? fp_out_t : fp_out;
   endtask

   task automatic test_reset();
      clr = 1'b1;
      repeat (2) @(posedge clk);
      #1 clr = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || fp_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_rnd: busy=%b done=%b fp=%h, want 0 0 00", busy, done, fp_out);
      end
      checks++;
      if (busy_t !== 1'b0 || done_t !== 1'b0 || fp_out_t !== 8'h00) begin
         errors++;
         $display("FAIL reset_trunc: busy=%b done=%b fp=%h, want 0 0 00", busy_t, done_t, fp_out_t);
      end
   endtask

   task automatic test_conversions();
      logic [7:0] prev [2] = '{8'h00, 8'h00};
      logic [7:0] fp;
      int n;
      exp_t e;
      for (int i = 0; i < NT; i++) begin
         issue(t_tr[i], t_in[i], t_fp[i], t_lat[i]);
         checks++;
         if ((t_tr[i] ? busy_t : busy) !== 1'b1 || (t_tr[i] ? fp_out_t : fp_out) !== prev[t_tr[i]]) begin
            errors++;
            $display("FAIL accept[%0d] in=%h: busy=%b fp=%h, want busy=1 fp held %h", i, t_in[i],
                     t_tr[i] ? busy_t : busy, t_tr[i] ? fp_out_t : fp_out, prev[t_tr[i]]);
         end
         wait_done(t_tr[i], n, fp);
         e = sb.pop_front();
         checks++;
         if (n !== e.lat || fp !== e.fp) begin
            errors++;
            $display("FAIL conv[%0d] in=%h trunc=%0d: fp=%h cycles=%0d, want fp=%h cycles=%0d",
                     i, t_in[i], t_tr[i], fp, n, e.fp, e.lat);
         end
         checks++;
         if ((t_tr[i] ? busy_t : busy) !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done[%0d]: busy=1, want 0", i);
         end
         prev[t_tr[i]] = e.fp;
         @(posedge clk); #1;
         checks++;
         if ((t_tr[i] ? done_t : done) !== 1'b0 || (t_tr[i] ? fp_out_t : fp_out) !== e.fp) begin
            errors++;
            $display("FAIL done_pulse[%0d]: done=%b fp=%h, want done=0 fp=%h", i,
                     t_tr[i] ? done_t : done, t_tr[i] ? fp_out_t : fp_out, e.fp);
         end
      end
   endtask

   task automatic test_ignore_midbusy();
      logic [7:0] fp;
      int n;
      bit extra;
      exp_t e;
      issue(1'b0, 8'h64, 8'h3C, 5);
      start = 1'b1; int_in = 8'h05;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(1'b0, n, fp);
      e = sb.pop_front();
      checks++;
      if (n + 1 !== e.lat || fp !== e.fp) begin
         errors++;
         $display("FAIL midbusy_start: fp=%h cycles=%0d, want fp=%h cycles=%0d", fp, n + 1, e.fp, e.lat);
      end
      extra = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done || busy) extra = 1'b1;
      end
      checks++;
      if (extra !== 1'b0) begin
         errors++;
         $display("FAIL midbusy_queued: extra activity=%b, want 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] fp;
      int n;
      exp_t e;
      start = 1'b1; int_in = 8'h18;
      sb.push_back('{8'h1C, 3});
      @(posedge clk); #1;
      int_in = 8'h7F;
      sb.push_back('{8'h48, 5});
      wait_done(1'b0, n, fp);
      e = sb.pop_front();
      checks++;
      if (n !== e.lat || fp !== e.fp) begin
         errors++;
         $display("FAIL b2b_first: fp=%h cycles=%0d, want fp=%h cycles=%0d", fp, n, e.fp, e.lat);
      end
      @(posedge clk); #1;
      start = 1'b0; int_in = 8'h00;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: busy=%b, want 1", busy);
      end
      wait_done(1'b0, n, fp);
      e = sb.pop_front();
      checks++;
      if (n !== e.lat || fp !== e.fp) begin
         errors++;
         $display("FAIL b2b_second: fp=%h cycles=%0d, want fp=%h cycles=%0d", fp, n, e.fp, e.lat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_clr_midconv();
      bit seen;
      issue(1'b0, 8'h7F, 8'h48, 5);
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      void'(sb.pop_front());
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || fp_out !== 8'h00) begin
         errors++;
         $display("FAIL clr_mid: busy=%b done=%b fp=%h, want 0 0 00", busy, done, fp_out);
      end
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL clr_done_pulse: done seen=%b, want 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_conversions();
      test_ignore_midbusy();
      test_back_to_back();
      test_clr_midconv();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
